// File: rtl/act_lut_fetcher.sv
// Activation LUT fetcher: splits a signed Q4.4 input into a table index and fraction, reads
// entries [index] and [index+1] from a synchronous ROM. Optional reuse cache: ACT_LUT_REUSE_EN.
module act_lut_fetcher #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FRAC_W = 4,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              tbl_flush,
    output logic [DATA_W-1:0] base,
    output logic [DATA_W-1:0] next_data,
    output logic [DATA_W-1:0] remaining,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [2:0] {StIdle, StRdBase, StRdNext, StCapNext, StOut} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] next_q, next_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0] in_addr, next_addr;
    logic [DATA_W-1:0] in_rem;
    logic              hit;

    // Offset-binary index: inverting the sign bit maps -8..+7 onto 0..15.
    assign in_addr   = {~x_in[DATA_W-1], x_in[DATA_W-2:FRAC_W]};
    assign in_rem    = {{(DATA_W-FRAC_W){1'b0}}, x_in[FRAC_W-1:0]};
    assign next_addr = (addr_q == {ADDR_W{1'b1}}) ? addr_q : addr_q + ADDR_W'(1);

`ifdef ACT_LUT_REUSE_EN
    logic reuse_q, reuse_d;

    assign hit = reuse_q && (in_addr == addr_q);

    always_comb begin
        reuse_d = reuse_q;
        if (state_q == StCapNext) reuse_d = 1'b1;
        if (tbl_flush)            reuse_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) reuse_q <= 1'b0;
        else     reuse_q <= reuse_d;
    end
`else
    logic unused_flush;

    assign hit          = 1'b0;
    assign unused_flush = tbl_flush;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rom_addr_d = rom_addr_q;
        base_d     = base_q;
        next_d     = next_q;
        rem_d      = rem_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        rom_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    addr_d = in_addr;
                    rem_d  = in_rem;
                    if (hit) begin
                        state_d = StOut;
                    end else begin
                        rom_addr_d = in_addr;
                        state_d    = StRdBase;
                    end
                end
            end
            StRdBase: begin
                rom_en     = 1'b1;
                rom_addr_d = next_addr;
                state_d    = StRdNext;
            end
            StRdNext: begin
                rom_en  = 1'b1;
                base_d  = rom_data;
                state_d = StCapNext;
            end
            StCapNext: begin
                next_d  = rom_data;
                state_d = StOut;
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            rom_addr_q <= '0;
            base_q     <= '0;
            next_q     <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rom_addr_q <= rom_addr_d;
            base_q     <= base_d;
            next_q     <= next_d;
            rem_q      <= rem_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign base      = base_q;
    assign next_data = next_q;
    assign remaining = rem_q;

endmodule
